// File: rtl/stream_mux_nto1.sv
// stream_mux_nto1: registered N-to-1 valid/ready stream multiplexer
// with fixed-select or round-robin channel arbitration.
module stream_mux_nto1 #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_ch
);

  logic [SEL_W-1:0] rr_last;
  logic             can_accept;
  logic             fix_ok;
  logic             rr_ok;
  logic [SEL_W-1:0] rr_gnt;
  logic             gnt_ok;
  logic [SEL_W-1:0] gnt;
  logic             gnt_valid;
  logic [WIDTH-1:0] gnt_data;
  logic             xfer;

  assign can_accept = !out_valid || out_ready;
  assign fix_ok     = 32'(sel) < 32'(NUM_CH);

  // Two passes: channels above rr_last first, then wrap to the rest.
  always_comb begin
    rr_ok  = 1'b0;
    rr_gnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rr_ok && in_valid[i] &&
          32'(i) > 32'(rr_last)) begin
        rr_ok  = 1'b1;
        rr_gnt = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rr_ok && in_valid[i] &&
          32'(i) <= 32'(rr_last)) begin
        rr_ok  = 1'b1;
        rr_gnt = SEL_W'(i);
      end
    end
  end

  always_comb begin
    gnt_ok = fix_ok;
    gnt    = sel;
    unique case (1'b1)
      mode: begin
        gnt_ok = rr_ok;
        gnt    = rr_gnt;
      end
      default: ;
    endcase
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt == SEL_W'(i)) begin
        gnt_valid = in_valid[i];
        gnt_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = rst_n && gnt_ok &&
                    can_accept &&
                    (gnt == SEL_W'(i));
    end
  end

  assign xfer = rst_n && gnt_ok &&
                can_accept && gnt_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_last   <= SEL_W'(NUM_CH - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_ch    <= gnt;
      if (mode) rr_last <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  a_one_ready: assert property (
    @(posedge clk) $onehot0(in_ready));

endmodule
